// File: rtl/reset_sequencer.sv
// Reset sequencer: holds every domain in reset for a fixed period and then
// releases the domains one at a time in index order. Each domain must report
// ready before the next one is released, after a fixed settling delay.
// A level software request re-resets all domains and restarts the sequence.
//
// Optional feature macro: RST_SEQ_TIMEOUT_EN
//   When defined, a domain that never reports ready within TIMEOUT cycles
//   raises a sticky err_timeout, forces every domain back into reset and
//   parks the block in ERR until a software reset handshake.
//   When undefined, the sequencer waits for ready indefinitely and
//   err_timeout is tied low.
module reset_sequencer #(
  parameter int N_DOM     = 4,
  parameter int HOLD_CYC  = 8,
  parameter int STAGE_DLY = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DOM-1:0] dom_ready,
  input  logic             sw_rst_req,
  output logic             sw_rst_ack,
  output logic [N_DOM-1:0] rst_dom,
  output logic             seq_busy,
  output logic             seq_done,
  output logic             err_timeout
);

  localparam int IDX_W = $clog2(N_DOM);

  // Counter end values: an event fires on the Nth edge of a state, i.e. when
  // the counter (cleared on entry) already holds N-1.
  localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYC - 1);
  localparam logic [7:0]       DLY_LAST  = 8'(STAGE_DLY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOM - 1);
`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [7:0]       TO_LAST   = 8'(TIMEOUT - 1);
`endif

  // REL is a recovery state: it re-releases domain idx and resumes waiting.
  // The normal flow releases straight from HOLD/WAIT_DLY so REL is not
  // entered, but it keeps any stray encoding pointing back into the flow.
  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    REL      = 3'd1,
    WAIT_RDY = 3'd2,
    WAIT_DLY = 3'd3,
    DONE     = 3'd4,
    SW_HOLD  = 3'd5
`ifdef RST_SEQ_TIMEOUT_EN
    ,
    ERR      = 3'd6
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic [N_DOM-1:0] rst_dom_q, rst_dom_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack_q, ack_d;
`ifdef RST_SEQ_TIMEOUT_EN
  logic             err_q, err_d;
`endif

  assign idx_nxt = idx_q + IDX_W'(1);

  // Next-state, counter, index and reset-vector decode. Software request is
  // checked first so it overrides every state, including a same-edge ready.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_dom_d = rst_dom_q;
`ifdef RST_SEQ_TIMEOUT_EN
    err_d     = err_q;
`endif
    cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    if (sw_rst_req) begin
      state_d   = SW_HOLD;
      rst_dom_d = '1;
      cnt_d     = '0;
      idx_d     = '0;
    end else begin
      case (state_q)
        HOLD: begin
          rst_dom_d = '1;
          if (cnt_q == HOLD_LAST) begin
            rst_dom_d[0] = 1'b0;
            idx_d        = '0;
            cnt_d        = '0;
            state_d      = WAIT_RDY;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        REL: begin
          rst_dom_d[idx_q] = 1'b0;
          cnt_d            = '0;
          state_d          = WAIT_RDY;
        end

        WAIT_RDY: begin
          if (dom_ready[idx_q]) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
            end else begin
              state_d = WAIT_DLY;
            end
          end else begin
`ifdef RST_SEQ_TIMEOUT_EN
            if (cnt_q == TO_LAST) begin
              err_d     = 1'b1;
              rst_dom_d = '1;
              cnt_d     = '0;
              state_d   = ERR;
            end else begin
              cnt_d = cnt_inc;
            end
`else
            cnt_d = cnt_inc;
`endif
          end
        end

        WAIT_DLY: begin
          if (cnt_q == DLY_LAST) begin
            rst_dom_d[idx_nxt] = 1'b0;
            idx_d              = idx_nxt;
            cnt_d              = '0;
            state_d            = WAIT_RDY;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        DONE: begin
          state_d = DONE;
        end

        SW_HOLD: begin
          rst_dom_d = '1;
          cnt_d     = '0;
          idx_d     = '0;
          state_d   = HOLD;
`ifdef RST_SEQ_TIMEOUT_EN
          err_d     = 1'b0;
`endif
        end

`ifdef RST_SEQ_TIMEOUT_EN
        ERR: begin
          rst_dom_d = '1;
          state_d   = ERR;
        end
`endif

        default: begin
          rst_dom_d = '1;
          cnt_d     = '0;
          idx_d     = '0;
          state_d   = HOLD;
        end
      endcase
    end
  end

  // Status flags follow the state being entered so they change on the same
  // edge as the state itself.
  always_comb begin
    busy_d = (state_d == HOLD) || (state_d == REL) ||
             (state_d == WAIT_RDY) || (state_d == WAIT_DLY);
    done_d = (state_d == DONE);
    ack_d  = (state_d == SW_HOLD);
  end

  // State and output registers with synchronous reset back to the start of
  // the hold period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_dom_q <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_dom_q <= rst_dom_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
    end
  end

`ifdef RST_SEQ_TIMEOUT_EN
  // Sticky timeout flag, cleared only by reset or a software reset handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign rst_dom    = rst_dom_q;
  assign seq_busy   = busy_q;
  assign seq_done   = done_q;
  assign sw_rst_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer with default parameters. Per-cycle vectors
// are built at the top from the release timeline, then applied one per clock;
// expected outputs go through a scoreboard queue and are compared after the
// edge. Honours RST_SEQ_TIMEOUT_EN when it is defined for the build.
module tb_reset_sequencer;

  localparam int N       = 4;
  localparam int HOLD    = 8;
  localparam int DLY     = 4;
  localparam int TO      = 16;
  localparam int BIG     = 1 << 30;

  logic         clk;
  logic         rst;
  logic [N-1:0] dom_ready;
  logic         sw_rst_req;
  logic         sw_rst_ack;
  logic [N-1:0] rst_dom;
  logic         seq_busy;
  logic         seq_done;
  logic         err_timeout;

  typedef struct {
    logic [N-1:0] dom;
    logic         busy;
    logic         done;
    logic         ack;
    logic         err;
    string        tag;
  } exp_t;

  typedef struct {
    logic         rst;
    logic         sw;
    logic [N-1:0] rdy;
    exp_t         e;
  } vec_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  reset_sequencer #(
    .N_DOM    (N),
    .HOLD_CYC (HOLD),
    .STAGE_DLY(DLY),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dom_ready  (dom_ready),
    .sw_rst_req (sw_rst_req),
    .sw_rst_ack (sw_rst_ack),
    .rst_dom    (rst_dom),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Append one hand-written vector.
  function automatic void addVec(logic r, logic sw, logic [N-1:0] rdy,
                                 logic [N-1:0] dom, logic busy, logic done,
                                 logic ack, logic err, string tag);
    vec_t v;
    v.rst    = r;
    v.sw     = sw;
    v.rdy    = rdy;
    v.e.dom  = dom;
    v.e.busy = busy;
    v.e.done = done;
    v.e.ack  = ack;
    v.e.err  = err;
    v.e.tag  = tag;
    vecs.push_back(v);
  endfunction

  // Append n edges of a release sequence starting right after a restart edge
  // (edge 0). Domain i is released at fall[i], its ready is first sampled two
  // edges later, and domain i+1 is released DLY edges after that sample.
  // A stuck domain never reports ready. A spurious ready on the last domain
  // is driven while domain 0 is being processed and must be ignored.
  function automatic void addRun(int n, int stuck, string tag);
    int   fall[N];
    int   samp[N];
    int   errAt;
    vec_t v;
    fall[0] = HOLD;
    for (int i = 0; i < N; i++) begin
      samp[i] = (i == stuck || fall[i] >= BIG) ? BIG : fall[i] + 2;
      if (i < N - 1) fall[i+1] = (samp[i] >= BIG) ? BIG : samp[i] + DLY;
    end
    errAt = BIG;
`ifdef RST_SEQ_TIMEOUT_EN
    if (stuck >= 0) errAt = fall[stuck] + TO;
`endif
    for (int k = 1; k <= n; k++) begin
      v.rst = 1'b0;
      v.sw  = 1'b0;
      for (int i = 0; i < N; i++) v.rdy[i] = (k >= samp[i]);
      if (k >= fall[0] && k < fall[1]) v.rdy[N-1] = 1'b1;
      if (k >= errAt) begin
        v.e.dom  = '1;
        v.e.busy = 1'b0;
        v.e.done = 1'b0;
        v.e.err  = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) v.e.dom[i] = !(k >= fall[i]);
        v.e.done = (k >= samp[N-1]);
        v.e.busy = !v.e.done;
        v.e.err  = 1'b0;
      end
      v.e.ack = 1'b0;
      v.e.tag = $sformatf("%s@%0d", tag, k);
      vecs.push_back(v);
    end
  endfunction

  // Drive one vector's inputs and queue its expected outputs.
  task automatic applyStimulus(input vec_t v);
    rst        = v.rst;
    sw_rst_req = v.sw;
    dom_ready  = v.rdy;
    sbq.push_back(v.e);
  endtask

  // Pop the oldest expectation and compare it with the registered outputs.
  task automatic checkOutput();
    exp_t e;
    logic [N+3:0] act;
    logic [N+3:0] req;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty actual=%b required=expectation", rst_dom);
      return;
    end
    e   = sbq.pop_front();
    act = {rst_dom, seq_busy, seq_done, sw_rst_ack, err_timeout};
    req = {e.dom, e.busy, e.done, e.ack, e.err};
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s {rst_dom,busy,done,ack,err} actual=%b required=%b",
               e.tag, act, req);
    end
  endtask

  initial begin
    int stuckLen;
    logic errHeld;
`ifdef RST_SEQ_TIMEOUT_EN
    stuckLen = 20 + TO + 4;
    errHeld  = 1'b1;
`else
    stuckLen = 1000;
    errHeld  = 1'b0;
`endif

    // Power-on reset followed by a complete release sequence.
    addVec(1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    addRun(30, -1, "normal");
    addVec(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, "done_rdy_low");
    addVec(1'b0, 1'b0, 4'b0101, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, "done_rdy_mix");

    // Three-cycle software reset from DONE, then a full restart.
    for (int i = 0; i < 3; i++)
      addVec(1'b0, 1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, "sw_from_done");
    addVec(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, "sw_exit1");

    // Abort while in the settling delay after domain 1 became ready.
    addRun(17, -1, "to_dly1");
    addVec(1'b0, 1'b1, 4'b0011, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, "sw_in_dly");
    addVec(1'b0, 1'b1, 4'b0011, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, "sw_in_dly2");
    addVec(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, "sw_exit2");

    // Software request and domain 1 ready on the same edge.
    addRun(15, -1, "to_rdy1");
    addVec(1'b0, 1'b1, 4'b0011, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, "sw_vs_ready");
    addVec(1'b0, 1'b0, 4'b0011, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, "sw_exit3");

    // Reset pulse while waiting for the last domain.
    addRun(27, -1, "to_rdy3");
    addVec(1'b1, 1'b0, 4'b0111, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid_seq");

    // Domain 2 never becomes ready.
    addRun(stuckLen, 2, "stuck2");
    addVec(1'b0, 1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, errHeld, "sw_after_stuck");
    addVec(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, "err_cleared");

    // Sequence still completes afterwards.
    addRun(28, -1, "final");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput();
    end

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter N_DOM, default 4, number of sequenced reset domains (2..8).
REQ-002 Parameter HOLD_CYC, default 8, cycles all domains are held in reset before the first release (1..255).
REQ-003 Parameter STAGE_DLY, default 4, cycles from sampling dom_ready[i] to releasing domain i+1 (1..255).
REQ-004 Parameter TIMEOUT, default 16, maximum cycles spent waiting for dom_ready[i] (1..255).
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 dom_ready  input  N_DOM  domain i reports it is out of reset and operational.
REQ-008 sw_rst_req  input  1  level request to re-reset all domains.
REQ-009 sw_rst_ack  output  1  high while all domains are held in reset on behalf of sw_rst_req.
REQ-010 rst_dom  output  N_DOM  active-high per-domain reset; released in index order 0..N_DOM-1.
REQ-011 seq_busy  output  1  high while a release sequence is in progress.
REQ-012 seq_done  output  1  high once every domain is released and ready.
REQ-013 err_timeout  output  1  sticky ready-timeout flag.

Function
REQ-014 The FSM SHALL have the states HOLD, REL, WAIT_RDY, WAIT_DLY, DONE, SW_HOLD and ERR, with the domain index idx and one 8-bit counter.
REQ-015 HOLD SHALL keep rst_dom all-ones, and the HOLD_CYC-th edge in HOLD SHALL clear rst_dom[0], set idx=0 and enter WAIT_RDY.
REQ-016 WAIT_RDY SHALL sample dom_ready[idx]; at the edge sampling it high, idx<N_DOM-1 -> WAIT_DLY, idx==N_DOM-1 -> DONE with seq_done=1 at that edge.
REQ-017 WAIT_DLY SHALL clear rst_dom[idx+1] and increment idx on its STAGE_DLY-th edge, then return to WAIT_RDY; rst_dom[i+1] therefore falls exactly STAGE_DLY edges after the edge sampling dom_ready[i] high.
REQ-018 Once cleared, a rst_dom bit SHALL remain low until the next HOLD, SW_HOLD, ERR or rst.
REQ-019 seq_busy SHALL be 1 in HOLD, REL, WAIT_RDY and WAIT_DLY, and 0 otherwise; seq_done SHALL be 1 only in DONE.
REQ-020 dom_ready for indices other than idx, and all dom_ready in DONE, SHALL be ignored.
REQ-021 sw_rst_req sampled high in any state SHALL set rst_dom all-ones and enter SW_HOLD at that edge, aborting any sequence in progress.
REQ-022 sw_rst_ack SHALL be 1 throughout SW_HOLD and 0 otherwise.
REQ-023 In SW_HOLD, sampling sw_rst_req low SHALL enter HOLD with the counter cleared, and SHALL clear err_timeout.
REQ-024 If sw_rst_req and dom_ready[idx] are both high on the same edge, sw_rst_req SHALL win.
REQ-025 The counter SHALL saturate and never wrap.

Reset
REQ-026 rst high at an edge SHALL force rst_dom all-ones, seq_busy=0, seq_done=0, sw_rst_ack=0, err_timeout=0, idx=0, counter=0 and state HOLD, regardless of current state.
REQ-027 seq_busy SHALL rise on the first edge with rst low; rst asserted mid-sequence SHALL restart the full HOLD period.

Configuration
REQ-028 With RST_SEQ_TIMEOUT_EN defined, the TIMEOUT-th consecutive edge in WAIT_RDY without dom_ready[idx] SHALL set err_timeout=1, set rst_dom all-ones and enter ERR.
REQ-029 ERR SHALL be left only via sw_rst_req (REQ-021) or rst.
REQ-030 Without RST_SEQ_TIMEOUT_EN, WAIT_RDY SHALL wait indefinitely, err_timeout SHALL be constant 0, and ERR and its logic SHALL be absent.

Verification (N_DOM=4, HOLD_CYC=8, STAGE_DLY=4, TIMEOUT=16)
REQ-031 Release rst and return dom_ready[i] high 2 cycles after rst_dom[i] falls -> rst_dom[0] falls at edge 8, bits 1..3 each fall 4 edges after the prior ready is sampled, seq_done rises with ready[3], and seq_busy falls the same edge.
REQ-032 Pulse sw_rst_req for 3 cycles in DONE -> rst_dom=4'b1111 and sw_rst_ack=1 for those 3 cycles, then a full sequence restarts with HOLD of 8.
REQ-033 Assert sw_rst_req while in WAIT_DLY for idx=1 -> next edge rst_dom=4'b1111, seq_busy=0, sw_rst_ack=1, and domains 2..3 are never released.
REQ-034 With the macro defined, hold dom_ready[2]=0 -> err_timeout=1 and rst_dom=4'b1111 on the 16th WAIT_RDY edge; the block stays in ERR until the sw_rst_req handshake clears the flag. Without the macro, the block waits 1000 cycles with err_timeout=0.
REQ-035 Assert rst for 1 cycle during WAIT_RDY for idx=3 -> all outputs return to reset values, and rst_dom[0] falls again 8 edges after rst falls.
REQ-036 Make dom_ready[1] and sw_rst_req high on the same edge -> SW_HOLD is entered and rst_dom[2] stays 1.
